argmax_unit: RTL and testbench
==============================

// Module: argmax_unit
// PURPOSE
//  Hardware argmax over NUM_CLASSES packed fixed-point scores. Sits after mnist_top:
//  takes its digit_scores bus and returns the predicted class index and winning score.
//  Scans one class per clock with start/done handshake; replaces the bench-side argmax.
//  Generalised in class count, score width and signed/unsigned compare.
// PARAMETERS
//  NUM_CLASSES  10  number of scores on the input bus (>=2)
//  SCORE_W      16  width of each score (Q8.8 at default)
//  SIGNED_CMP   1   1: two's-complement compare; 0: unsigned compare
//  IDX_W        $clog2(NUM_CLASSES)  width of the index output (derived, do not override)
// PORTS
//  clk        in   1                   system clock
//  rst        in   1                   synchronous, active-high reset
//  start      in   1                   begin argmax; sampled only in IDLE
//  scores     in   NUM_CLASSES*SCORE_W class i at scores[i*SCORE_W +: SCORE_W]
//  busy       out  1                   high while in SCAN
//  done       out  1                   one-cycle pulse, result valid
//  pred_idx   out  IDX_W               index of the maximum score
//  max_score  out  SCORE_W             value of the maximum score
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-high (rst). Reset: state=IDLE,
//    busy=0, done=0, pred_idx=0, max_score=0, snapshot register cleared.
//  - FSM IDLE -> SCAN -> DONE -> IDLE.
//    IDLE: on start=1, snapshot whole scores bus, best_val=score[0], best_idx=0,
//      ptr=1, go SCAN. start=0: stay.
//    SCAN: busy=1; compare snap[ptr] vs best_val; replace only if strictly greater;
//      ptr++. After ptr==NUM_CLASSES-1 is compared, go DONE.
//    DONE: load pred_idx/max_score from best, done=1 for exactly this cycle, go IDLE.
//  - Latency: start sampled at edge T; done high in cycle T+NUM_CLASSES
//    (10 cycles at default). Back-to-back: start in the cycle after done is accepted.
//  - Tie-break: lowest index wins (strict > during ascending scan).
//  - Compare: SIGNED_CMP=1 treats 16'h8000 as most negative; SIGNED_CMP=0 treats it
//    as 32768. No arithmetic on scores; no width growth.
//  - Input changes after the start edge do not affect the result (snapshot).
//  - start while busy or in DONE: ignored, no restart, no queueing.
//  - start held high: one run per IDLE visit; re-triggers each time IDLE is re-entered.
//  - pred_idx/max_score hold the last result until the next DONE; not cleared by start.
//  - rst mid-SCAN: abort, return to reset values next cycle, no done pulse.
// CONFIGURATION
//  ARGMAX_TOP2_EN defined: extra outputs second_idx [IDX_W] and margin [SCORE_W]
//    (max_score - second score, always >=0, computed at DONE). Runner-up tracked
//    during SCAN. Tie with best -> becomes second. On replacement of best, old best
//    -> second. second_idx and margin reset to 0, update with pred_idx.
//  Not defined: ports and tracking logic absent; primary behaviour identical.
// STRUCTURE
//  - mnist_pkg: NUM_CLASSES=10, SCORE_W=16 defaults, argmax state enum
//    (ST_IDLE, ST_SCAN, ST_DONE), idx width function.
//  - Sub-module argmax_cmp: combinational a>b, signed/unsigned by SIGNED_CMP;
//    instantiated once (twice with ARGMAX_TOP2_EN).
// TESTING
//  1 Default params, scores 0..9 = 0x0100*i -> done after 10 cycles, pred_idx=9,
//    max_score=16'h0900.
//  2 Ties: digits 3 and 7 both 16'h0480, others 16'h0010 -> pred_idx=3.
//  3 Signed: all 16'hFF00 (-1.0) except digit 5 = 16'hFFF0 -> pred_idx=5; same
//    vector with SIGNED_CMP=0 plus digit 2 = 16'h8000 -> pred_idx=5 (0xFFF0 largest).
//  4 start pulse at scan cycle 4 and scores bus changed mid-scan -> single done,
//    result from the snapshot taken at the start edge.
//  5 rst at scan cycle 6 -> no done, outputs 0; new start -> correct result in 10 cycles.
//  6 ARGMAX_TOP2_EN, digit 8=16'h0700, digit 1=16'h0500, rest 0 -> pred_idx=8,
//    second_idx=1, margin=16'h0200; NUM_CLASSES=4 build -> done after 4 cycles.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared defaults, argmax FSM state encoding and index-width helper for the classifier back end.
package mnist_pkg;

  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_SCORE_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

  // Index width for n classes; a two-class build still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: combinational a > b, two's-complement when SIGNED_CMP is nonzero, else unsigned.
module argmax_cmp #(
  parameter int W          = 16,
  parameter int SIGNED_CMP = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  // Strict greater-than; equal operands never win, which gives the lowest-index tie-break
  always_comb begin
    gt = 1'b0;
    if (SIGNED_CMP != 0) begin
      gt = ($signed(a) > $signed(b));
    end else begin
      gt = (a > b);
    end
  end

endmodule

// File: rtl/argmax_unit.sv
// argmax_unit: scans a snapshot of NUM_CLASSES scores one class per clock and reports the winner.
// Defining ARGMAX_TOP2_EN adds runner-up tracking with second_idx and margin outputs.
module argmax_unit
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int SIGNED_CMP  = 1,
  localparam int IDX_W      = idx_width(NUM_CLASSES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  output logic                           busy,
  output logic                           done,
  output logic [IDX_W-1:0]               pred_idx,
  output logic [SCORE_W-1:0]             max_score
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]               second_idx,
  output logic [SCORE_W-1:0]             margin
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e      state_r;
  argmax_state_e      state_nxt;
  logic [SCORE_W-1:0] snap_r [NUM_CLASSES];
  logic [IDX_W-1:0]   ptr_r;
  logic [SCORE_W-1:0] best_val_r;
  logic [IDX_W-1:0]   best_idx_r;
  logic [SCORE_W-1:0] cand_s;
  logic               gt_best_s;
  logic               busy_nxt;
  logic               done_nxt;

  assign cand_s = snap_r[ptr_r];

  argmax_cmp #(.W(SCORE_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp_best (
    .a  (cand_s),
    .b  (best_val_r),
    .gt (gt_best_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SCAN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (ptr_r == LAST_IDX) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SCAN;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode feeding the registered status and result outputs
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == ST_SCAN) begin
      busy_nxt = 1'b1;
    end else begin
      busy_nxt = 1'b0;
    end
    if (state_r == ST_DONE) begin
      done_nxt = 1'b1;
    end else begin
      done_nxt = 1'b0;
    end
  end

  // Snapshot capture at start, then running best over the ascending scan
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) snap_r[i] <= '0;
      ptr_r      <= '0;
      best_val_r <= '0;
      best_idx_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_CLASSES; i++) snap_r[i] <= scores[i*SCORE_W +: SCORE_W];
            best_val_r <= scores[SCORE_W-1:0];
            best_idx_r <= '0;
            ptr_r      <= IDX_W'(1);
          end
        end
        ST_SCAN: begin
          if (gt_best_s) begin
            best_val_r <= cand_s;
            best_idx_r <= ptr_r;
          end
          // Pointer parks on the last class so the snapshot read never goes out of range
          if (ptr_r != LAST_IDX) ptr_r <= ptr_r + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; results hold until the next completed scan
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pred_idx  <= '0;
      max_score <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (done_nxt) begin
        pred_idx  <= best_idx_r;
        max_score <= best_val_r;
      end
    end
  end

`ifdef ARGMAX_TOP2_EN
  logic [SCORE_W-1:0] sec_val_r;
  logic [IDX_W-1:0]   sec_idx_r;
  logic               sec_vld_r;
  logic               gt_sec_s;

  argmax_cmp #(.W(SCORE_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp_second (
    .a  (cand_s),
    .b  (sec_val_r),
    .gt (gt_sec_s)
  );

  // Runner-up tracking: displaced best drops to second; a tie with best also becomes second
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_val_r  <= '0;
      sec_idx_r  <= '0;
      sec_vld_r  <= 1'b0;
      second_idx <= '0;
      margin     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) sec_vld_r <= 1'b0;
        end
        ST_SCAN: begin
          if (gt_best_s) begin
            sec_val_r <= best_val_r;
            sec_idx_r <= best_idx_r;
            sec_vld_r <= 1'b1;
          end else if (!sec_vld_r || gt_sec_s || (cand_s == best_val_r)) begin
            sec_val_r <= cand_s;
            sec_idx_r <= ptr_r;
            sec_vld_r <= 1'b1;
          end
        end
        default: ;
      endcase
      if (done_nxt) begin
        second_idx <= sec_idx_r;
        margin     <= best_val_r - sec_val_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_argmax_unit.sv
// Directed-vector bench for argmax_unit: signed/unsigned and 4-class builds plus multi-cycle corner sequences.
module tb_argmax_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_m, start_u, start_4;
  logic [159:0] sc_m, sc_u;
  logic [63:0]  sc_4;
  logic         busy_m, busy_u, busy_4, done_m, done_u, done_4;
  logic [3:0]   pred_m, pred_u;
  logic [1:0]   pred_4;
  logic [15:0]  max_m, max_u, max_4;
`ifdef ARGMAX_TOP2_EN
  logic [3:0]   sec_m, sec_u;
  logic [1:0]   sec_4;
  logic [15:0]  mar_m, mar_u, mar_4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  argmax_unit dut_m (.clk(clk), .rst(rst), .start(start_m), .scores(sc_m), .busy(busy_m), .done(done_m),
                     .pred_idx(pred_m), .max_score(max_m)
`ifdef ARGMAX_TOP2_EN
                     , .second_idx(sec_m), .margin(mar_m)
`endif
                     );
  argmax_unit #(.SIGNED_CMP(0)) dut_u (.clk(clk), .rst(rst), .start(start_u), .scores(sc_u), .busy(busy_u),
                     .done(done_u), .pred_idx(pred_u), .max_score(max_u)
`ifdef ARGMAX_TOP2_EN
                     , .second_idx(sec_u), .margin(mar_u)
`endif
                     );
  argmax_unit #(.NUM_CLASSES(4)) dut_4 (.clk(clk), .rst(rst), .start(start_4), .scores(sc_4), .busy(busy_4),
                     .done(done_4), .pred_idx(pred_4), .max_score(max_4)
`ifdef ARGMAX_TOP2_EN
                     , .second_idx(sec_4), .margin(mar_4)
`endif
                     );

  typedef struct {
    int           which;   // 0 signed 10-class, 1 unsigned 10-class, 2 signed 4-class
    logic [159:0] sc;
    int           lat;
    int           idx;
    int           mx;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [159:0] fill(input logic [15:0] v);
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [159:0] setd(input logic [159:0] v, input int d, input logic [15:0] s);
    logic [159:0] r;
    r = v;
    r[d*16 +: 16] = s;
    return r;
  endfunction

  function automatic longint idx_of(input int w);
    case (w)
      1:       return longint'(pred_u);
      2:       return longint'(pred_4);
      default: return longint'(pred_m);
    endcase
  endfunction

  function automatic longint max_of(input int w);
    case (w)
      1:       return longint'(max_u);
      2:       return longint'(max_4);
      default: return longint'(max_m);
    endcase
  endfunction

  // Pulse start on one instance and count edges until its done; -1 when the bound expires
  task automatic run(input int which, input logic [159:0] sc, output int lat);
    lat = -1;
    case (which)
      1:       begin sc_u = sc;        start_u = 1'b1; end
      2:       begin sc_4 = sc[63:0];  start_4 = 1'b1; end
      default: begin sc_m = sc;        start_m = 1'b1; end
    endcase
    @(posedge clk); #1;
    start_m = 1'b0; start_u = 1'b0; start_4 = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if ((which == 0 && done_m) || (which == 1 && done_u) || (which == 2 && done_4)) lat = k;
    end
  endtask

  logic [159:0] ramp, desc, ties, v;
  int lat, ndone, first, second;

  initial begin
    rst = 1'b1;
    start_m = 1'b0; start_u = 1'b0; start_4 = 1'b0;
    sc_m = '0; sc_u = '0; sc_4 = '0;

    for (int i = 0; i < 10; i++) begin
      ramp[i*16 +: 16] = 16'(i * 256);
      desc[i*16 +: 16] = 16'(16'h0900 - i * 256);
    end
    ties = setd(setd(fill(16'h0010), 3, 16'h0480), 7, 16'h0480);

    vecs[0]  = '{0, ramp, 10, 9, 32'h0900};
    vecs[1]  = '{0, ties, 10, 3, 32'h0480};
    vecs[2]  = '{0, setd(fill(16'hFF00), 5, 16'hFFF0), 10, 5, 32'hFFF0};
    vecs[3]  = '{0, desc, 10, 0, 32'h0900};
    vecs[4]  = '{0, fill(16'h1234), 10, 0, 32'h1234};
    vecs[5]  = '{0, setd(setd(fill(16'hFF00), 0, 16'h8000), 9, 16'h7FFF), 10, 9, 32'h7FFF};
    vecs[6]  = '{1, setd(setd(fill(16'hFF00), 5, 16'hFFF0), 2, 16'h8000), 10, 5, 32'hFFF0};
    vecs[7]  = '{1, setd(setd(fill(16'h0000), 0, 16'h7FFF), 3, 16'h8000), 10, 3, 32'h8000};
    vecs[8]  = '{2, {96'h0, 16'h0001, 16'h0002, 16'h0010, 16'h0003}, 4, 1, 32'h0010};
    vecs[9]  = '{2, {96'h0, 16'h0500, 16'h0400, 16'h0400, 16'h0400}, 4, 3, 32'h0500};
    vecs[10] = '{0, setd(setd(fill(16'h0000), 8, 16'h0700), 1, 16'h0500), 10, 8, 32'h0700};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", busy_m, 0);
    check("reset_done", done_m, 0);
    check("reset_pred", pred_m, 0);
    check("reset_max", max_m, 0);

    for (int i = 0; i < 11; i++) begin
      run(vecs[i].which, vecs[i].sc, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_pred_idx", i), idx_of(vecs[i].which), vecs[i].idx);
      check($sformatf("vec%0d_max_score", i), max_of(vecs[i].which), vecs[i].mx);
      repeat (2) @(posedge clk);
      #1;
    end
`ifdef ARGMAX_TOP2_EN
    check("top2_second_idx", sec_m, 1);
    check("top2_margin", mar_m, 16'h0200);
`endif

    // Start during scan is ignored and bus changes after the start edge do not leak in
    sc_m = ramp; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    ndone = 0; first = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) check("hold_pred_during_scan", pred_m, 8);
      if (k == 3) sc_m = ties;
      if (k == 4) start_m = 1'b1;
      if (k == 5) begin start_m = 1'b0; check("busy_in_scan", busy_m, 1); end
      @(posedge clk); #1;
      if (done_m) begin ndone++; if (first < 0) first = k; end
    end
    check("midscan_done_count", ndone, 1);
    check("midscan_latency", first, 10);
    check("midscan_pred", pred_m, 9);
    check("midscan_max", max_m, 16'h0900);

    // Reset mid-scan aborts without a done pulse, then a fresh run works
    sc_m = ties; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_pred", pred_m, 0);
    check("abort_max", max_m, 0);
    check("abort_busy", busy_m, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done_m) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run(0, ramp, lat);
    check("after_abort_latency", lat, 10);
    check("after_abort_pred", pred_m, 9);

    // start held high re-triggers once per IDLE visit
    sc_m = desc; start_m = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = -1; second = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1;
      if (done_m) begin
        ndone++;
        if (first < 0) first = k; else if (second < 0) second = k;
      end
    end
    start_m = 1'b0;
    check("held_start_dones", ndone, 2);
    check("held_start_first", first, 10);
    check("held_start_second", second, 21);
    check("held_start_pred", pred_m, 0);
    repeat (15) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
